// File: rtl/ishift_n_if.sv
// Operand/result bus of the iterative shifter; sticky exists only with ISHIFT_N_STICKY_EN.
interface ishift_n_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 5
);
    logic             go;
    logic [1:0]       fmt;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             c;
`ifdef ISHIFT_N_STICKY_EN
    logic             sticky;

    modport master (output go, fmt, cnt, a, input busy, done, y, c, sticky);
    modport slave  (input go, fmt, cnt, a, output busy, done, y, c, sticky);
`else
    modport master (output go, fmt, cnt, a, input busy, done, y, c);
    modport slave  (input go, fmt, cnt, a, output busy, done, y, c);
`endif
endinterface

// File: rtl/ishift_n.sv
// Iterative shifter/rotator: up to STEP bits per clock, done strobe, carry-out.
// Optional sticky output (OR of shifted-out bits) enabled by ISHIFT_N_STICKY_EN.
module ishift_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 5,
    parameter int unsigned STEP  = 1
) (
    input  logic        clk,
    input  logic        arstn,
    ishift_n_if.slave   bus
);
    localparam int unsigned RW = $clog2(WIDTH + 1);

    localparam logic [1:0] F_LSR = 2'd0;
    localparam logic [1:0] F_LSL = 2'd1;
    localparam logic [1:0] F_ASR = 2'd2;
    localparam logic [1:0] F_ROR = 2'd3;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [1:0]       fmt_q, fmt_d;
    logic [RW-1:0]    clamp_c;
    logic             out_b;
`ifdef ISHIFT_N_STICKY_EN
    logic             sticky_q, sticky_d;
`endif

    // Shifts saturate at WIDTH; rotates wrap modulo WIDTH (a power of two).
    always_comb begin
        if (bus.fmt == F_ROR) begin
            clamp_c = RW'(bus.cnt & CNTW'(WIDTH - 1));
        end else if (32'(bus.cnt) > WIDTH) begin
            clamp_c = RW'(WIDTH);
        end else begin
            clamp_c = RW'(bus.cnt);
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        y_d      = y_q;
        c_d      = c_q;
        rem_d    = rem_q;
        fmt_d    = fmt_q;
        out_b    = 1'b0;
`ifdef ISHIFT_N_STICKY_EN
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    y_d      = bus.a;
                    fmt_d    = bus.fmt;
                    c_d      = 1'b0;
                    rem_d    = clamp_c;
`ifdef ISHIFT_N_STICKY_EN
                    sticky_d = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // Unrolled single-bit steps, each gated by the remaining count.
                    for (int i = 0; i < int'(STEP); i++) begin
                        if (RW'(i) < rem_q) begin
                            unique case (fmt_q)
                                F_LSL: begin
                                    out_b = y_d[WIDTH-1];
                                    y_d   = {y_d[WIDTH-2:0], 1'b0};
                                end
                                F_ASR: begin
                                    out_b = y_d[0];
                                    y_d   = {y_d[WIDTH-1], y_d[WIDTH-1:1]};
                                end
                                F_ROR: begin
                                    out_b = 1'b0;
                                    y_d   = {y_d[0], y_d[WIDTH-1:1]};
                                end
                                default: begin
                                    out_b = y_d[0];
                                    y_d   = {1'b0, y_d[WIDTH-1:1]};
                                end
                            endcase
                            c_d   = (fmt_q == F_ROR) ? y_d[WIDTH-1] : out_b;
                            rem_d = rem_d - RW'(1);
`ifdef ISHIFT_N_STICKY_EN
                            sticky_d = sticky_d | out_b;
`endif
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= '0;
            c_q      <= 1'b0;
            rem_q    <= '0;
            fmt_q    <= '0;
`ifdef ISHIFT_N_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            y_q      <= y_d;
            c_q      <= c_d;
            rem_q    <= rem_d;
            fmt_q    <= fmt_d;
`ifdef ISHIFT_N_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.y      = y_q;
    assign bus.c      = c_q;
`ifdef ISHIFT_N_STICKY_EN
    assign bus.sticky = sticky_q;
`endif

endmodule

// File: tb/tb_ishift_n.sv
// Directed bench for ishift_n: three configurations (16/1, 16/4, 32/2) share one stimulus bus.
module tb_ishift_n;
    logic        clk;
    logic        arstn;
    logic        go;
    logic [1:0]  fmt;
    logic [5:0]  cnt;
    logic [31:0] a;
    int          sel;
    int          n_tests;
    int          n_fail;

    logic        s_busy, s_done, s_c, s_sticky;
    logic [31:0] s_y;

    ishift_n_if #(.WIDTH(16), .CNTW(5)) if0 ();
    ishift_n_if #(.WIDTH(16), .CNTW(5)) if1 ();
    ishift_n_if #(.WIDTH(32), .CNTW(6)) if2 ();

    assign if0.go = go;  assign if0.fmt = fmt;  assign if0.cnt = cnt[4:0];  assign if0.a = a[15:0];
    assign if1.go = go;  assign if1.fmt = fmt;  assign if1.cnt = cnt[4:0];  assign if1.a = a[15:0];
    assign if2.go = go;  assign if2.fmt = fmt;  assign if2.cnt = cnt;       assign if2.a = a;

    ishift_n #(.WIDTH(16), .CNTW(5), .STEP(1)) u0 (.clk(clk), .arstn(arstn), .bus(if0));
    ishift_n #(.WIDTH(16), .CNTW(5), .STEP(4)) u1 (.clk(clk), .arstn(arstn), .bus(if1));
    ishift_n #(.WIDTH(32), .CNTW(6), .STEP(2)) u2 (.clk(clk), .arstn(arstn), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // View of the instance under test.
    always_comb begin
        s_sticky = 1'b0;
        case (sel)
            1: begin
                s_busy = if1.busy; s_done = if1.done; s_c = if1.c; s_y = {16'h0, if1.y};
`ifdef ISHIFT_N_STICKY_EN
                s_sticky = if1.sticky;
`endif
            end
            2: begin
                s_busy = if2.busy; s_done = if2.done; s_c = if2.c; s_y = if2.y;
`ifdef ISHIFT_N_STICKY_EN
                s_sticky = if2.sticky;
`endif
            end
            default: begin
                s_busy = if0.busy; s_done = if0.done; s_c = if0.c; s_y = {16'h0, if0.y};
`ifdef ISHIFT_N_STICKY_EN
                s_sticky = if0.sticky;
`endif
            end
        endcase
    end

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (!if0.busy && !if1.busy && !if2.busy) break;
            @(negedge clk);
        end
    endtask

    // One go pulse, then follow the selected instance until done (bounded).
    // ndone: 0 = timed out, 1 = single strobe, 2 = strobe lasted too long; ovl = busy&done seen.
    task automatic run_op(input logic [31:0] ia, input logic [5:0] icnt, input logic [1:0] ifmt,
                          input int isel, output int bcyc, output int ndone, output logic ovl,
                          output logic [31:0] ry, output logic rc, output logic rs);
        wait_idle();
        sel = isel;
        @(negedge clk);
        a = ia; cnt = icnt; fmt = ifmt; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        bcyc = 0; ndone = 0; ovl = 1'b0; ry = '0; rc = 1'b0; rs = 1'b0;
        for (int k = 0; k < 100 && ndone == 0; k++) begin
            if (s_busy && s_done) ovl = 1'b1;
            if (s_busy) bcyc++;
            if (s_done) begin
                ndone = 1; ry = s_y; rc = s_c; rs = s_sticky;
            end else begin
                @(negedge clk);
            end
        end
        if (ndone == 1) begin
            @(negedge clk);
            if (s_done) ndone = 2;
        end
    endtask

    task automatic test_reset();
        arstn = 1'b0; go = 1'b0; a = '0; cnt = '0; fmt = '0; sel = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_tests++;
            if ({s_busy, s_done, s_c, s_sticky} !== 4'b0 || s_y !== 32'h0) begin
                n_fail++;
                $display("FAIL reset inst%0d: busy=%b done=%b c=%b sticky=%b y=%h, want all 0",
                         s, s_busy, s_done, s_c, s_sticky, s_y);
            end
        end
        @(negedge clk);
        arstn = 1'b1;
    endtask

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [5:0]  cnt;
        logic [1:0]  fmt;
        logic [31:0] ey;
        logic        ec;
        int          eb;
    } vec_t;

    task automatic test_directed_vectors();
        vec_t tv [14];
        int bcyc, ndone;
        logic ovl, rc, rs;
        logic [31:0] ry;
        tv = '{
            '{0, 32'h0064,     6'd2,  2'd0, 32'h0019,     1'b0, 3},
            '{0, 32'h0064,     6'd3,  2'd1, 32'h0320,     1'b0, 4},
            '{0, 32'hFC18,     6'd2,  2'd2, 32'hFF06,     1'b0, 3},
            '{0, 32'hFC18,     6'd2,  2'd0, 32'h3F06,     1'b0, 3},
            '{0, 32'hBEEF,     6'd0,  2'd1, 32'hBEEF,     1'b0, 1},
            '{0, 32'hFFFF,     6'd16, 2'd0, 32'h0000,     1'b1, 17},
            '{1, 32'h1234,     6'd8,  2'd3, 32'h3412,     1'b0, 3},
            '{1, 32'h1234,     6'd20, 2'd3, 32'h4123,     1'b0, 2},
            '{1, 32'h8001,     6'd31, 2'd0, 32'h0000,     1'b1, 5},
            '{1, 32'h0001,     6'd6,  2'd1, 32'h0040,     1'b0, 3},
            '{1, 32'h8000,     6'd17, 2'd2, 32'hFFFF,     1'b1, 5},
            '{2, 32'h80000001, 6'd40, 2'd2, 32'hFFFFFFFF, 1'b1, 17},
            '{2, 32'h80000001, 6'd40, 2'd1, 32'h00000000, 1'b1, 17},
            '{2, 32'h80000001, 6'd33, 2'd3, 32'hC0000000, 1'b1, 2}
        };
        for (int i = 0; i < 14; i++) begin
            run_op(tv[i].a, tv[i].cnt, tv[i].fmt, tv[i].sel, bcyc, ndone, ovl, ry, rc, rs);
            n_tests++;
            if (ndone !== 1) begin
                n_fail++;
                $display("FAIL vec%0d done: strobe state %0d, want 1 (single strobe)", i, ndone);
            end
            n_tests++;
            if (ry !== tv[i].ey || rc !== tv[i].ec) begin
                n_fail++;
                $display("FAIL vec%0d result: y=%h c=%b, want y=%h c=%b", i, ry, rc, tv[i].ey, tv[i].ec);
            end
            n_tests++;
            if (bcyc !== tv[i].eb || ovl !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d busy: %0d cycles overlap=%b, want %0d cycles overlap=0",
                         i, bcyc, ovl, tv[i].eb);
            end
        end
    endtask

    task automatic test_go_ignored();
        int bcyc, ndone, extra;
        logic [31:0] ry;
        wait_idle();
        sel = 0;
        @(negedge clk);
        a = 32'h00F0; cnt = 6'd4; fmt = 2'd0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        a = 32'hFFFF; cnt = 6'd1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        bcyc = 2; ndone = 0; ry = '0;
        for (int k = 0; k < 50 && ndone == 0; k++) begin
            if (s_busy) bcyc++;
            if (s_done) begin ndone = 1; ry = s_y; end
            else @(negedge clk);
        end
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (s_busy || s_done) extra++;
        end
        n_tests++;
        if (ndone !== 1 || ry !== 32'h000F || bcyc !== 5) begin
            n_fail++;
            $display("FAIL go_ignored: done=%0d y=%h busy=%0d, want 1 000f 5", ndone, ry, bcyc);
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL go_ignored queue: %0d busy/done cycles after finish, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int t_first, t_second;
        logic [31:0] ry;
        wait_idle();
        sel = 0;
        @(negedge clk);
        a = 32'h0010; cnt = 6'd1; fmt = 2'd0; go = 1'b1;
        t_first = -1; t_second = -1; ry = '0;
        for (int k = 0; k < 40 && t_second < 0; k++) begin
            @(negedge clk);
            if (s_done) begin
                if (t_first < 0) begin t_first = k; ry = s_y; end
                else t_second = k;
            end
        end
        go = 1'b0;
        n_tests++;
        if (t_first < 0 || t_second < 0 || (t_second - t_first) !== 3) begin
            n_fail++;
            $display("FAIL back_to_back period: done at %0d and %0d, want spacing 3", t_first, t_second);
        end
        n_tests++;
        if (ry !== 32'h0008) begin
            n_fail++;
            $display("FAIL back_to_back result: y=%h, want 0008", ry);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        wait_idle();
        sel = 0;
        @(negedge clk);
        a = 32'hFFFF; cnt = 6'd10; fmt = 2'd0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        arstn = 1'b0;
        #1;
        n_tests++;
        if (s_busy !== 1'b0 || s_y !== 32'h0 || s_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b y=%h done=%b, want 0 0 0", s_busy, s_y, s_done);
        end
        @(negedge clk);
        arstn = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_done || s_busy) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_abort resume: %0d busy/done cycles after abort, want 0", dones);
        end
    endtask

`ifdef ISHIFT_N_STICKY_EN
    task automatic test_sticky();
        logic [31:0] sa [4];
        logic [5:0]  sc [4];
        logic [1:0]  sf [4];
        logic [31:0] ey [4];
        logic        ec [4];
        logic        es [4];
        int bcyc, ndone;
        logic ovl, rc, rs;
        logic [31:0] ry;
        sa = '{32'h0005, 32'h0004, 32'h0005, 32'h8000};
        sc = '{6'd2,     6'd2,     6'd2,     6'd1};
        sf = '{2'd0,     2'd0,     2'd3,     2'd1};
        ey = '{32'h0001, 32'h0001, 32'h4001, 32'h0000};
        ec = '{1'b0,     1'b0,     1'b0,     1'b1};
        es = '{1'b1,     1'b0,     1'b0,     1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(sa[i], sc[i], sf[i], 0, bcyc, ndone, ovl, ry, rc, rs);
            n_tests++;
            if (ndone !== 1 || ry !== ey[i] || rc !== ec[i] || rs !== es[i]) begin
                n_fail++;
                $display("FAIL sticky%0d: done=%0d y=%h c=%b sticky=%b, want 1 %h %b %b",
                         i, ndone, ry, rc, rs, ey[i], ec[i], es[i]);
            end
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed_vectors();
        test_go_ignored();
        test_back_to_back();
        test_reset_abort();
`ifdef ISHIFT_N_STICKY_EN
        test_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ishift_n.md
Name: ishift_n

Overview:
- Parametrised iterative shifter/rotator for the coprocessor; successor of the fixed 16-bit serial shifter.
- Shifts a latched operand by up to STEP bits per clock until the count is exhausted.
- Adds a rotate mode, a carry-out bit and a one-cycle done strobe.
- Width, count width and per-cycle step are generic; the busy/go handshake is unchanged, so existing sequencer code drives it directly.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a power of 2, minimum 8.
- CNTW, 5, width of shift-count input.
- STEP, 1, maximum bits shifted per clock; must be 1, 2, 4 or 8, and STEP <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- arstn  input  1  asynchronous active-low reset.
- go  input  1  start request; sampled on a rising edge of clk.
- fmt  input  2  shift mode: 0 = LSR, 1 = LSL, 2 = ASR, 3 = ROR (rotate right).
- cnt  input  CNTW  shift count.
- a  input  WIDTH  operand.
- busy  output  1  operation in progress.
- done  output  1  one-cycle strobe when the result is valid.
- y  output  WIDTH  result register.
- c  output  1  last bit shifted out; for ROR, the bit rotated into the MSB.
- sticky  output  1  OR of all bits shifted out; present only with ISHIFT_N_STICKY_EN.

Behaviour:
- Reset (arstn low, asynchronous): busy = 0, done = 0, y = 0, c = 0, sticky = 0, internal remaining count = 0, latched fmt = 0.
  - Reset in mid-operation aborts immediately.
  - No done strobe is produced for an aborted operation.
- States: IDLE (busy = 0) and RUN (busy = 1).
- IDLE, go = 1 at a clock edge:
  - Latch y <= a and fmt; clear c and sticky; busy <= 1.
  - remaining <= count clamp:
    - fmt 0/1/2: min(cnt, WIDTH).
    - fmt 3: cnt mod WIDTH.
- RUN, remaining != 0:
  - s = min(STEP, remaining); shift y by s in the latched mode; remaining <= remaining - s.
  - LSR: zero fill from the MSB; c = last bit shifted out of the LSB.
  - LSL: zero fill from the LSB; c = last bit shifted out of the MSB.
  - ASR: sign fill from y[WIDTH-1]; c as for LSR.
  - ROR: bits leaving the LSB enter the MSB; c = new y[WIDTH-1].
  - Clamped counts give: LSR/LSL result 0; ASR result all sign bits.
- RUN, remaining == 0: busy <= 0; done <= 1 for exactly one cycle. y, c and sticky hold until the next accepted go.
- Latency: busy is high for ceil(rc/STEP) + 1 cycles, where rc = the clamped remaining count.
  - cnt = 0: busy is high for 1 cycle; y = a, c = 0.
  - done rises on the same edge that busy falls.
- go while busy = 1 is ignored; no queuing.
- go on the edge where busy falls is also ignored. It is accepted on the next edge if still asserted.
- a, cnt and fmt may change freely after the go edge; only the latched values are used.
- go held high continuously: a new operation starts every ceil(rc/STEP) + 2 cycles.
- done and busy are never both 1.

Optional Feature:
- Macro: ISHIFT_N_STICKY_EN.
- Defined:
  - The sticky port exists.
  - sticky is cleared on go; every RUN cycle ORs in all bits shifted out of the operand.
  - For ROR, sticky stays 0.
  - sticky is valid with done and holds with y.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour and timing are identical.

Test Plan:
- WIDTH=16, STEP=1: a = 100, cnt = 2, fmt = 0 -> y = 25, c = 0; busy high 3 cycles; one done pulse.
- WIDTH=16, STEP=1:
  - a = 100, cnt = 3, fmt = 1 -> y = 800.
  - a = 0xFC18 (-1000), cnt = 2, fmt = 2 -> y = 0xFF06 (-250).
  - Same a, fmt = 0 -> y = 0x3F06 (16134), c = 0.
- WIDTH=16, STEP=4:
  - a = 0x1234, cnt = 8, fmt = 3 -> y = 0x3412, busy high 3 cycles.
  - cnt = 20, fmt = 3 -> y = 0x4123, since the count reduces to 4.
- WIDTH=32, CNTW=6, STEP=2:
  - a = 0x80000001, cnt = 40, fmt = 2 -> y = 0xFFFFFFFF, busy high 17 cycles.
  - Same a, fmt = 1 -> y = 0, c = 1.
- Handshake:
  - cnt = 0 -> y = a, busy high 1 cycle.
  - go re-pulsed during busy with a different a -> ignored; result unchanged.
  - arstn pulsed low mid-run -> y = 0, busy = 0, no done.
- With ISHIFT_N_STICKY_EN defined:
  - a = 0x0005, cnt = 2, fmt = 0 -> y = 1, c = 0, sticky = 1.
  - a = 0x0004, cnt = 2 -> y = 1, sticky = 0.
